snake_draw_engine: RTL and testbench

- Datapath stage between the snake game controller and the 160x120, 3-bit-colour VGA pixel writer.
- Accepts grid-level snake step requests and food requests from the controller.
- Keeps the snake body in a circular position buffer.
- Drives the pixel writer's x/y/colour/plot as a serial stream of pixel writes: clear screen, erase tail, draw head, draw food.
- Reports body length and error pulses back to the controller.

---
 rtl/snake_draw_engine_pkg.sv | 45 ++++
 rtl/snake_draw_engine_if.sv | 46 ++++
 rtl/snake_draw_engine_pos_buffer.sv | 63 ++++++
 rtl/snake_draw_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_snake_draw_engine.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_draw_engine_pkg.sv
// Shared grid geometry, colours, FSM states and cell type for the snake draw engine.
// Build option SNAKE_SELF_HIT_EN adds the SCAN state.
package snake_pkg;

    localparam int unsigned GRID_W    = 40;
    localparam int unsigned GRID_H    = 30;
    localparam int unsigned CELL_LOG2 = 2;
    localparam int unsigned SCREEN_W  = GRID_W << CELL_LOG2;
    localparam int unsigned SCREEN_H  = GRID_H << CELL_LOG2;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_SNAKE = 3'b010;
    localparam logic [2:0] COL_FOOD  = 3'b100;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ERASE_TAIL,
        ST_DRAW_HEAD,
        ST_DRAW_FOOD
`ifdef SNAKE_SELF_HIT_EN
        ,
        ST_SCAN
`endif
    } state_t;

    typedef struct packed {
        logic [5:0] gx;
        logic [4:0] gy;
    } cell_t;

    function automatic logic cell_in_grid(cell_t c);
        return (32'(c.gx) < GRID_W) && (32'(c.gy) < GRID_H);
    endfunction

    // Packed {x[7:0], y[6:0]} of pixel `sub` (sub-x in the low two bits) of a 4x4 cell.
    function automatic logic [14:0] pix_xy(cell_t c, logic [3:0] sub);
        logic [7:0] px;
        logic [6:0] py;
        px = {c.gx, 2'b00} + {6'd0, sub[1:0]};
        py = {c.gy, 2'b00} + {5'd0, sub[3:2]};
        return {px, py};
    endfunction

endpackage

// File: rtl/snake_draw_engine_if.sv
// Controller/pixel-writer signal bundle of the snake draw engine.
// Build option SNAKE_SELF_HIT_EN adds the hit pulse.
interface snake_draw_engine_if;

    logic       step_valid;
    logic       step_ready;
    logic [5:0] step_gx;
    logic [4:0] step_gy;
    logic       step_grow;
    logic       food_valid;
    logic       food_ready;
    logic [5:0] food_gx;
    logic [4:0] food_gy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [6:0] length;
    logic       full;
    logic       bad_coord;

`ifdef SNAKE_SELF_HIT_EN
    logic       hit;

    modport master (
        output step_valid, step_gx, step_gy, step_grow, food_valid, food_gx, food_gy,
        input  step_ready, food_ready, x, y, colour, plot, length, full, bad_coord, hit
    );

    modport slave (
        input  step_valid, step_gx, step_gy, step_grow, food_valid, food_gx, food_gy,
        output step_ready, food_ready, x, y, colour, plot, length, full, bad_coord, hit
    );
`else
    modport master (
        output step_valid, step_gx, step_gy, step_grow, food_valid, food_gx, food_gy,
        input  step_ready, food_ready, x, y, colour, plot, length, full, bad_coord
    );

    modport slave (
        input  step_valid, step_gx, step_gy, step_grow, food_valid, food_gx, food_gy,
        output step_ready, food_ready, x, y, colour, plot, length, full, bad_coord
    );
`endif

endinterface

// File: rtl/snake_draw_engine_pos_buffer.sv
// Circular buffer of snake body cells: push at head, pop at tail.
// Build option SNAKE_SELF_HIT_EN adds a random read port indexed from the tail.
module snake_pos_buffer
    import snake_pkg::*;
#(
    parameter  int unsigned MAX_LEN = 64,
    localparam int unsigned PW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  cell_t         i_push_cell,
    input  logic          i_pop,
    output cell_t         o_tail_cell,
`ifdef SNAKE_SELF_HIT_EN
    input  logic [PW-1:0] i_rd_idx,
    output cell_t         o_rd_cell,
`endif
    output logic [PW:0]   o_count,
    output logic          o_empty,
    output logic          o_full
);

    cell_t         r_mem [MAX_LEN];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_head] <= i_push_cell;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_head <= r_head + 1'b1;
            end
            if (i_pop) begin
                r_tail <= r_tail + 1'b1;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_tail_cell = r_mem[r_tail];
`ifdef SNAKE_SELF_HIT_EN
    assign o_rd_cell   = r_mem[r_tail + i_rd_idx];
`endif
    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == (PW + 1)'(MAX_LEN));

endmodule

// File: rtl/snake_draw_engine.sv
// Snake draw engine: turns grid-level step/food requests into a serial pixel-write stream.
// Build option SNAKE_SELF_HIT_EN adds a self-collision SCAN before drawing and the hit pulse.
module snake_draw_engine
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64
) (
    input logic                clk,
    input logic                reset_n,
    snake_draw_engine_if.slave bus
);

    localparam int unsigned PW = $clog2(MAX_LEN);

    state_t      r_state;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_plot;
    logic        r_step_ready;
    logic        r_food_ready;
    logic        r_full;
    logic        r_bad;
    logic [3:0]  r_sub;
    cell_t       r_head_cell;
    cell_t       r_draw_cell;
    logic        r_erase;

    cell_t       w_step_cell;
    cell_t       w_food_cell;
    cell_t       w_tail_cell;
    logic [PW:0] w_count;
    logic        w_buf_empty;
    logic        w_buf_full;
    logic        w_step_hs;
    logic        w_food_hs;
    logic        w_erase;
    logic        w_last_sub;
    logic [3:0]  w_next_sub;
    logic        w_push;
    logic        w_pop;

    assign w_step_cell = {bus.step_gx, bus.step_gy};
    assign w_food_cell = {bus.food_gx, bus.food_gy};
    assign w_step_hs   = bus.step_valid && r_step_ready;
    // A simultaneous step wins; food stays pending at the controller.
    assign w_food_hs   = bus.food_valid && r_food_ready && !bus.step_valid;
    assign w_erase     = (!bus.step_grow || w_buf_full) && !w_buf_empty;
    assign w_last_sub  = (r_sub == 4'hF);
    assign w_next_sub  = r_sub + 4'd1;
    // Tail pop and head push share the DRAW_HEAD exit so length moves only when drawing completes.
    assign w_push      = (r_state == ST_DRAW_HEAD) && w_last_sub;
    assign w_pop       = w_push && r_erase;

`ifdef SNAKE_SELF_HIT_EN
    logic [PW-1:0] r_idx;
    logic          r_hit;
    cell_t         w_rd_cell;
    logic          w_scan_live;
    logic          w_scan_match;
    logic          w_scan_last;

    assign w_scan_live  = ({1'b0, r_idx} < w_count) && (!r_erase || (r_idx != '0));
    assign w_scan_match = w_scan_live && (w_rd_cell == r_head_cell);
    assign w_scan_last  = (({1'b0, r_idx} + 1'b1) >= w_count);
    assign bus.hit      = r_hit;
`endif

    snake_pos_buffer #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clk         (clk),
        .rst_n       (reset_n),
        .i_push      (w_push),
        .i_push_cell (r_head_cell),
        .i_pop       (w_pop),
        .o_tail_cell (w_tail_cell),
`ifdef SNAKE_SELF_HIT_EN
        .i_rd_idx    (r_idx),
        .o_rd_cell   (w_rd_cell),
`endif
        .o_count     (w_count),
        .o_empty     (w_buf_empty),
        .o_full      (w_buf_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_CLEAR;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= COL_BLACK;
            r_plot       <= 1'b0;
            r_step_ready <= 1'b0;
            r_food_ready <= 1'b0;
            r_full       <= 1'b0;
            r_bad        <= 1'b0;
            r_sub        <= '0;
            r_head_cell  <= '0;
            r_draw_cell  <= '0;
            r_erase      <= 1'b0;
`ifdef SNAKE_SELF_HIT_EN
            r_idx        <= '0;
            r_hit        <= 1'b0;
`endif
        end else begin
            r_full <= 1'b0;
            r_bad  <= 1'b0;
`ifdef SNAKE_SELF_HIT_EN
            r_hit  <= 1'b0;
`endif
            unique case (r_state)
                ST_CLEAR: begin
                    if (!r_plot) begin
                        r_plot   <= 1'b1;
                        r_colour <= COL_BLACK;
                    end else if ((r_x == 8'(SCREEN_W - 1)) && (r_y == 7'(SCREEN_H - 1))) begin
                        r_state      <= ST_IDLE;
                        r_plot       <= 1'b0;
                        r_step_ready <= 1'b1;
                        r_food_ready <= 1'b1;
                    end else if (r_x == 8'(SCREEN_W - 1)) begin
                        r_x <= '0;
                        r_y <= r_y + 7'd1;
                    end else begin
                        r_x <= r_x + 8'd1;
                    end
                end

                ST_IDLE: begin
                    if (w_step_hs) begin
                        if (!cell_in_grid(w_step_cell)) begin
                            r_bad <= 1'b1;
                        end else begin
                            r_step_ready <= 1'b0;
                            r_food_ready <= 1'b0;
                            r_head_cell  <= w_step_cell;
                            r_erase      <= w_erase;
                            r_full       <= bus.step_grow && w_buf_full;
                            r_sub        <= '0;
`ifdef SNAKE_SELF_HIT_EN
                            r_state      <= ST_SCAN;
                            r_idx        <= '0;
`else
                            r_plot       <= 1'b1;
                            if (w_erase) begin
                                r_state     <= ST_ERASE_TAIL;
                                r_draw_cell <= w_tail_cell;
                                r_colour    <= COL_BLACK;
                                {r_x, r_y}  <= pix_xy(w_tail_cell, 4'd0);
                            end else begin
                                r_state     <= ST_DRAW_HEAD;
                                r_draw_cell <= w_step_cell;
                                r_colour    <= COL_SNAKE;
                                {r_x, r_y}  <= pix_xy(w_step_cell, 4'd0);
                            end
`endif
                        end
                    end else if (w_food_hs) begin
                        if (!cell_in_grid(w_food_cell)) begin
                            r_bad <= 1'b1;
                        end else begin
                            r_step_ready <= 1'b0;
                            r_food_ready <= 1'b0;
                            r_state      <= ST_DRAW_FOOD;
                            r_draw_cell  <= w_food_cell;
                            r_colour     <= COL_FOOD;
                            r_plot       <= 1'b1;
                            r_sub        <= '0;
                            {r_x, r_y}   <= pix_xy(w_food_cell, 4'd0);
                        end
                    end
                end

`ifdef SNAKE_SELF_HIT_EN
                ST_SCAN: begin
                    if (w_scan_match) begin
                        r_state      <= ST_IDLE;
                        r_hit        <= 1'b1;
                        r_step_ready <= 1'b1;
                        r_food_ready <= 1'b1;
                    end else if (w_scan_last) begin
                        r_plot <= 1'b1;
                        r_sub  <= '0;
                        if (r_erase) begin
                            r_state     <= ST_ERASE_TAIL;
                            r_draw_cell <= w_tail_cell;
                            r_colour    <= COL_BLACK;
                            {r_x, r_y}  <= pix_xy(w_tail_cell, 4'd0);
                        end else begin
                            r_state     <= ST_DRAW_HEAD;
                            r_draw_cell <= r_head_cell;
                            r_colour    <= COL_SNAKE;
                            {r_x, r_y}  <= pix_xy(r_head_cell, 4'd0);
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
`endif

                ST_ERASE_TAIL, ST_DRAW_HEAD, ST_DRAW_FOOD: begin
                    if (!w_last_sub) begin
                        r_sub      <= w_next_sub;
                        {r_x, r_y} <= pix_xy(r_draw_cell, w_next_sub);
                    end else if (r_state == ST_ERASE_TAIL) begin
                        r_state     <= ST_DRAW_HEAD;
                        r_sub       <= '0;
                        r_draw_cell <= r_head_cell;
                        r_colour    <= COL_SNAKE;
                        {r_x, r_y}  <= pix_xy(r_head_cell, 4'd0);
                    end else begin
                        r_state      <= ST_IDLE;
                        r_plot       <= 1'b0;
                        r_step_ready <= 1'b1;
                        r_food_ready <= 1'b1;
                    end
                end

                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign bus.step_ready = r_step_ready;
    assign bus.food_ready = r_food_ready;
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.colour     = r_colour;
    assign bus.plot       = r_plot;
    assign bus.length     = 7'(w_count);
    assign bus.full       = r_full;
    assign bus.bad_coord  = r_bad;

endmodule

// File: tb/tb_snake_draw_engine.sv
// Scoreboard bench for snake_draw_engine: stimulus queues expected pixels, a monitor pops on plot.
module tb_snake_draw_engine;
    import snake_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    snake_draw_engine_if bus ();

    snake_draw_engine #(
        .MAX_LEN (64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    pix_t  sb[$];
    cell_t body[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_plots  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every plotted pixel must match the head of the expected queue.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (bus.plot) begin
                n_plots++;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, expected no write",
                             bus.x, bus.y, bus.colour);
                end else begin
                    e = sb.pop_front();
                    if (bus.x == e.x && bus.y == e.y && bus.colour == e.c) n_pass++;
                    else $display("FAIL pixel: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                                  bus.x, bus.y, bus.colour, e.x, e.y, e.c);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_cell(input int gx, input int gy, input logic [2:0] col);
        pix_t p;
        for (int s = 0; s < 16; s++) begin
            p.x = 8'(gx * 4 + s % 4);
            p.y = 7'(gy * 4 + s / 4);
            p.c = col;
            sb.push_back(p);
        end
    endtask

    task automatic push_clear();
        pix_t p;
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                p.x = 8'(xx);
                p.y = 7'(yy);
                p.c = 3'b000;
                sb.push_back(p);
            end
        end
    endtask

    // Called at posedge+1; returns cycle index (1 = first cycle after accept) when ready seen.
    task automatic wait_step_ready(input int bound, output int cyc);
        cyc = 1;
        while (!bus.step_ready && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic wait_food_ready(input int bound, output int cyc);
        cyc = 1;
        while (!bus.food_ready && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic issue_step(input int gx, input int gy, input bit grow);
        int cyc;
        wait_step_ready(200, cyc);
        bus.step_gx    = 6'(gx);
        bus.step_gy    = 5'(gy);
        bus.step_grow  = grow;
        bus.step_valid = 1'b1;
        @(posedge clk); #1;
        bus.step_valid = 1'b0;
    endtask

    task automatic issue_food(input int gx, input int gy);
        int cyc;
        wait_food_ready(200, cyc);
        bus.food_gx    = 6'(gx);
        bus.food_gy    = 5'(gy);
        bus.food_valid = 1'b1;
        @(posedge clk); #1;
        bus.food_valid = 1'b0;
    endtask

    // Model a valid step: returns whether the tail is erased and queues the expected pixels.
    task automatic model_step(input int gx, input int gy, input bit grow,
                              output bit erase, output bit full_exp);
        cell_t c;
        c.gx     = 6'(gx);
        c.gy     = 5'(gy);
        full_exp = grow && (body.size() == 64);
        erase    = (!grow || full_exp) && (body.size() > 0);
        if (erase) begin
            push_cell(int'(body[0].gx), int'(body[0].gy), 3'b000);
            void'(body.pop_front());
        end
        push_cell(gx, gy, 3'b010);
        body.push_back(c);
    endtask

    task automatic do_step(input int gx, input int gy, input bit grow);
        bit erase, full_exp;
        int cyc;
        model_step(gx, gy, grow, erase, full_exp);
        issue_step(gx, gy, grow);
        check("full_pulse", int'(bus.full), int'(full_exp));
        check("bad_coord_quiet", int'(bus.bad_coord), 0);
        wait_step_ready(200, cyc);
        check("step_ready_return", int'(bus.step_ready), 1);
        check("step_latency", cyc, erase ? 33 : 17);
        check("length", int'(bus.length), body.size());
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic do_reset_clear();
        int cyc;
        n_plots = 0;
        push_clear();
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_step_ready(20000, cyc);
        check("clear_ready", int'(bus.step_ready), 1);
        check("clear_food_ready", int'(bus.food_ready), 1);
        check("clear_plot_count", n_plots, 19200);
        check("clear_sb_drained", sb.size(), 0);
        check("clear_last_x", int'(bus.x), 159);
        check("clear_last_y", int'(bus.y), 119);
    endtask

    initial begin
        bit erase, full_exp;
        int cyc, len_before;

        bus.step_valid = 1'b0;
        bus.step_gx    = '0;
        bus.step_gy    = '0;
        bus.step_grow  = 1'b0;
        bus.food_valid = 1'b0;
        bus.food_gx    = '0;
        bus.food_gy    = '0;

        // Reset values
        #23;
        check("rst_plot", int'(bus.plot), 0);
        check("rst_x", int'(bus.x), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_colour", int'(bus.colour), 0);
        check("rst_length", int'(bus.length), 0);
        check("rst_step_ready", int'(bus.step_ready), 0);
        check("rst_food_ready", int'(bus.food_ready), 0);
        check("rst_full", int'(bus.full), 0);
        check("rst_bad", int'(bus.bad_coord), 0);
        do_reset_clear();

        // Grow onto empty buffer, then a plain move one cell right
        do_step(10, 5, 1'b1);
        do_step(11, 5, 1'b0);

        // Step and food together: step wins, food follows once ready returns
        model_step(12, 5, 1'b0, erase, full_exp);
        push_cell(3, 3, 3'b100);
        bus.step_gx    = 6'd12;
        bus.step_gy    = 5'd5;
        bus.step_grow  = 1'b0;
        bus.food_gx    = 6'd3;
        bus.food_gy    = 5'd3;
        bus.step_valid = 1'b1;
        bus.food_valid = 1'b1;
        @(posedge clk); #1;
        bus.step_valid = 1'b0;
        check("both_food_ready_low", int'(bus.food_ready), 0);
        check("both_step_ready_low", int'(bus.step_ready), 0);
        check("both_first_colour", int'(bus.colour), 0);
        wait_step_ready(200, cyc);
        check("both_step_latency", cyc, 33);
        check("both_length", int'(bus.length), 1);
        @(posedge clk); #1;
        bus.food_valid = 1'b0;
        check("food_first_colour", int'(bus.colour), 4);
        wait_food_ready(200, cyc);
        check("food_latency", cyc, 17);
        check("food_sb_drained", sb.size(), 0);
        check("food_length", int'(bus.length), 1);

        // Out-of-grid step and food are consumed with a single bad_coord pulse
        len_before = int'(bus.length);
        issue_step(40, 0, 1'b1);
        check("bad_step_pulse", int'(bus.bad_coord), 1);
        check("bad_step_ready", int'(bus.step_ready), 1);
        @(posedge clk); #1;
        check("bad_step_pulse_end", int'(bus.bad_coord), 0);
        check("bad_step_length", int'(bus.length), len_before);
        issue_food(0, 30);
        check("bad_food_pulse", int'(bus.bad_coord), 1);
        @(posedge clk); #1;
        check("bad_food_pulse_end", int'(bus.bad_coord), 0);
        check("bad_food_length", int'(bus.length), len_before);

        // Fill to capacity, overflow with grows, then wrap the pointers further
        for (int i = 0; body.size() < 64; i++) begin
            do_step(i % 40, 10 + i / 40, 1'b1);
        end
        check("filled_length", int'(bus.length), 64);
        do_step(30, 20, 1'b1);
        do_step(31, 20, 1'b1);
        do_step(32, 20, 1'b0);
        do_step(33, 20, 1'b1);
        check("wrap_length", int'(bus.length), 64);

        // Reset in the middle of DRAW_HEAD of a non-grow step
        model_step(34, 21, 1'b0, erase, full_exp);
        issue_step(34, 21, 1'b0);
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("mid_plot_before", int'(bus.plot), 1);
        check("mid_colour_before", int'(bus.colour), 2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_plot", int'(bus.plot), 0);
        check("mid_rst_length", int'(bus.length), 0);
        check("mid_rst_ready", int'(bus.step_ready), 0);
        check("mid_rst_x", int'(bus.x), 0);
        sb.delete();
        body.delete();
        #15;
        do_reset_clear();
        do_step(5, 5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
